// File: rtl/adder_pkg.sv
// Shared widths and controller state for the nibble-serial adder.
package adder_pkg;
  localparam int NIBBLE_W = 4;
  localparam int IDX_W    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    MID  = 1'b1
  } state_t;
endpackage

// File: rtl/nibble_rca4.sv
// 4-bit ripple-carry adder core built from four full-adder cells.
// Purely combinational; no handshake of its own.
module nibble_rca4
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder streaming LS-first nibble pairs with a registered inter-beat carry.
// Latency 1 cycle, one beat per cycle.
// Single-entry output register; in_ready drops while a result is held and not taken.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int MAX_BEATS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_a,
  input  logic [NIBBLE_W-1:0] in_b,
  input  logic                in_cin,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIBBLE_W-1:0] out_sum,
  output logic                out_cout,
  output logic                out_last,
  output logic [IDX_W-1:0]    out_idx,
  output logic                len_err
);

  state_t              state;
  logic                carry_q;
  logic [IDX_W-1:0]    beat_cnt;

  logic                accept;
  logic                core_cin;
  logic [NIBBLE_W-1:0] core_sum;
  logic                core_cout;
  logic                force_end;
  logic                word_end;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign core_cin  = (state == IDLE) ? in_cin : carry_q;
  assign force_end = (beat_cnt == IDX_W'(MAX_BEATS - 1));
  assign word_end  = in_last || force_end;

  nibble_rca4 u_core (
    .a    (in_a),
    .b    (in_b),
    .cin  (core_cin),
    .sum  (core_sum),
    .cout (core_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      carry_q   <= 1'b0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      len_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= core_sum;
      out_cout  <= core_cout;
      out_idx   <= beat_cnt;
      out_last  <= word_end;
      if (force_end && !in_last)
        len_err <= 1'b1;
      // Closing a word always clears the carry so it cannot bleed into the next one.
      if (word_end) begin
        state    <= IDLE;
        carry_q  <= 1'b0;
        beat_cnt <= '0;
      end else begin
        state    <= MID;
        carry_q  <= core_cout;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
